// File: rtl/lfsr_checker.sv
// ---------------------------------------------------------------------------
// lfsr_checker
//
// Checks a serial bit stream against the 8-bit LFSR sequence defined by the
// prediction p = s[0]^s[2]^s[3]^s[4] with shift s <= {new, s[7:1]}.
//
// Operation:
//   HUNT   - load 8 accepted bits into s. An all-zero load is rejected, because
//            that LFSR state never advances, and the load restarts.
//   VERIFY - compare each accepted bit with the prediction. LOCK_CNT
//            consecutive matches give lock. Any mismatch goes back to HUNT.
//   LOCKED - s runs free on its own predictions, so a single corrupted input
//            bit gives exactly one mismatch. Mismatches are counted in err_cnt
//            and in a WINDOW-bit window. ERR_LIMIT mismatches in one window
//            drop lock.
//
// Handshake: bit_in is consumed on every rising edge where bit_valid=1. There
//            is no back-pressure, so the checker is always ready. On an edge
//            with bit_valid=0 nothing advances, except that clr_err still
//            clears err_cnt and err_pulse returns low.
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst       in   synchronous active-high reset, overrides everything
//   bit_in    in   serial data bit under test
//   bit_valid in   qualifies bit_in
//   clr_err   in   clears err_cnt on this edge (wins over an increment)
//   locked    out  high while in LOCKED
//   err_cnt   out  saturating count of mismatches seen while LOCKED
//   err_pulse out  one-cycle pulse after each mismatch counted in LOCKED
//   state     out  FSM state: HUNT=0, VERIFY=1, LOCKED=2
// ---------------------------------------------------------------------------
module lfsr_checker #(
  parameter int LOCK_CNT  = 16,
  parameter int ERR_LIMIT = 4,
  parameter int WINDOW    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_in,
  input  logic        bit_valid,
  input  logic        clr_err,
  output logic        locked,
  output logic [15:0] err_cnt,
  output logic        err_pulse,
  output logic [1:0]  state
);

  // Counter widths are sized to hold the terminal value itself.
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WINDOW + 1);
  localparam int EW = $clog2(ERR_LIMIT + 1);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [7:0]    s_q, s_d;
  logic [3:0]    load_q, load_d;
  logic [MW-1:0] match_q, match_d;
  logic [WW-1:0] wbit_q, wbit_d;
  logic [EW-1:0] werr_q, werr_d;
  logic [15:0]   err_q, err_d;
  logic          pulse_q, pulse_d;

  // Shared decode terms.
  logic          p;
  logic          mismatch;
  logic [7:0]    s_load;
  logic          load_done;
  logic          lockup;
  logic          match_done;
  logic [EW-1:0] werr_inc;
  logic          win_fail;
  logic          win_wrap;
  logic          count_err;

  assign p          = s_q[0] ^ s_q[2] ^ s_q[3] ^ s_q[4];
  assign mismatch   = bit_in ^ p;
  assign s_load     = {bit_in, s_q[7:1]};
  assign load_done  = (load_q == 4'd7);
  // The all-zero state is a fixed point of the LFSR, so it cannot be tracked.
  assign lockup     = (s_load == 8'h00);
  assign match_done = (match_q == MW'(LOCK_CNT - 1));
  // The bit that wraps the window still counts toward the old window, so the
  // limit is tested on the incremented count before the wrap clears it.
  assign werr_inc   = werr_q + EW'(mismatch);
  assign win_fail   = mismatch && (werr_inc == EW'(ERR_LIMIT));
  assign win_wrap   = (wbit_q == WW'(WINDOW - 1));
  assign count_err  = bit_valid && (state_q == LOCKED) && mismatch;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (bit_valid) begin
      case (state_q)
        HUNT: begin
          if (load_done && !lockup) begin
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (mismatch) begin
            state_d = HUNT;
          end else if (match_done) begin
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (win_fail) begin
            state_d = HUNT;
          end
        end
        default: state_d = HUNT;  // unused encoding recovers to HUNT
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    locked = (state_q == LOCKED);
    state  = state_q;
  end

  // -------------------------------------------------------------------------
  // Datapath next values: shift register, counters, error count
  // -------------------------------------------------------------------------
  always_comb begin
    s_d     = s_q;
    load_d  = load_q;
    match_d = match_q;
    wbit_d  = wbit_q;
    werr_d  = werr_q;
    if (bit_valid) begin
      case (state_q)
        HUNT: begin
          s_d     = s_load;
          // When the 8th bit is loaded the count returns to 0, whether the
          // load was accepted or rejected as all-zero.
          load_d  = load_done ? 4'd0 : load_q + 4'd1;
          match_d = '0;
        end
        VERIFY: begin
          s_d    = s_load;
          wbit_d = '0;
          werr_d = '0;
          if (mismatch || match_done) begin
            load_d  = 4'd0;
            match_d = '0;
          end else begin
            match_d = match_q + MW'(1);
          end
        end
        LOCKED: begin
          // Free-running reference: the input is only compared, never loaded.
          s_d = {p, s_q[7:1]};
          if (win_fail) begin
            load_d  = 4'd0;
            match_d = '0;
            wbit_d  = '0;
            werr_d  = '0;
          end else if (win_wrap) begin
            wbit_d = '0;
            werr_d = '0;
          end else begin
            wbit_d = wbit_q + WW'(1);
            werr_d = werr_inc;
          end
        end
        default: begin
          load_d  = 4'd0;
          match_d = '0;
          wbit_d  = '0;
          werr_d  = '0;
        end
      endcase
    end
  end

  // err_cnt survives loss of lock. Only reset and clr_err clear it, and
  // clr_err wins over an increment on the same edge.
  always_comb begin
    err_d = err_q;
    if (count_err && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end
    if (clr_err) begin
      err_d = 16'd0;
    end
    pulse_d = count_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= 8'h00;
      load_q  <= 4'd0;
      match_q <= '0;
      wbit_q  <= '0;
      werr_q  <= '0;
      err_q   <= 16'd0;
      pulse_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      load_q  <= load_d;
      match_q <= match_d;
      wbit_q  <= wbit_d;
      werr_q  <= werr_d;
      err_q   <= err_d;
      pulse_q <= pulse_d;
    end
  end

  assign err_cnt   = err_q;
  assign err_pulse = pulse_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// ---------------------------------------------------------------------------
// tb_lfsr_checker
//
// Self-checking bench for lfsr_checker.
//
// u_dut runs with the default parameters. After every edge its state,
// locked, err_cnt and err_pulse are compared with a behavioural model. The
// model keeps the last eight bits as a history queue and applies the lock,
// window and error rules with plain integers.
//
// u_sat uses ERR_LIMIT = WINDOW+1, so it can never lose lock. It is driven
// with a long run of mismatches to reach err_cnt saturation.
// ---------------------------------------------------------------------------
module tb_lfsr_checker;

  localparam int LOCK_CNT  = 16;
  localparam int ERR_LIMIT = 4;
  localparam int WINDOW    = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, bit_in, bit_valid, clr_err;
  logic        locked, err_pulse;
  logic [15:0] err_cnt;
  logic [1:0]  state;

  logic        s_rst, s_bit, s_valid, s_clr;
  logic        s_locked, s_pulse;
  logic [15:0] s_err;
  logic [1:0]  s_state;

  lfsr_checker #(.LOCK_CNT(LOCK_CNT), .ERR_LIMIT(ERR_LIMIT), .WINDOW(WINDOW)) u_dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clr_err(clr_err),
    .locked(locked), .err_cnt(err_cnt), .err_pulse(err_pulse), .state(state)
  );

  lfsr_checker #(.LOCK_CNT(LOCK_CNT), .ERR_LIMIT(WINDOW + 1), .WINDOW(WINDOW)) u_sat (
    .clk(clk), .rst(s_rst), .bit_in(s_bit), .bit_valid(s_valid), .clr_err(s_clr),
    .locked(s_locked), .err_cnt(s_err), .err_pulse(s_pulse), .state(s_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Mode: 0 = hunting, 1 = verifying, 2 = locked.
  int m_mode, m_loads, m_matches, m_wbits, m_werrs, m_err;
  bit m_pulse;
  bit m_hist[$];  // last eight bits of the tracked sequence, oldest first
  bit ever_locked;

  task automatic hist_push(input bit b);
    m_hist.push_back(b);
    void'(m_hist.pop_front());
  endtask

  task automatic model_step(input bit v, input bit b, input bit c, input bit r);
    bit pred;
    bit mis;
    bit any_one;
    if (r) begin
      m_mode = 0; m_loads = 0; m_matches = 0; m_wbits = 0; m_werrs = 0;
      m_err = 0; m_pulse = 0;
      m_hist.delete();
      repeat (8) m_hist.push_back(1'b0);
      return;
    end
    m_pulse = 0;
    if (v) begin
      // Recurrence taps are the bits 8, 6, 5 and 4 positions back.
      pred = m_hist[m_hist.size()-8] ^ m_hist[m_hist.size()-6]
           ^ m_hist[m_hist.size()-5] ^ m_hist[m_hist.size()-4];
      case (m_mode)
        0: begin
          hist_push(b);
          m_loads++;
          if (m_loads == 8) begin
            m_loads = 0;
            any_one = 0;
            foreach (m_hist[i]) any_one |= m_hist[i];
            if (any_one) begin
              m_mode = 1;
              m_matches = 0;
            end
          end
        end
        1: begin
          hist_push(b);
          if (b == pred) begin
            m_matches++;
            if (m_matches == LOCK_CNT) begin
              m_mode = 2; m_wbits = 0; m_werrs = 0;
            end
          end else begin
            m_mode = 0; m_loads = 0; m_matches = 0;
          end
        end
        default: begin
          hist_push(pred);
          mis = (b != pred);
          if (mis) begin
            m_pulse = 1;
            if (m_err < 65535) m_err++;
          end
          m_wbits++;
          m_werrs += int'(mis);
          if (m_werrs == ERR_LIMIT) begin
            m_mode = 0; m_loads = 0; m_matches = 0; m_wbits = 0; m_werrs = 0;
          end else if (m_wbits == WINDOW) begin
            m_wbits = 0; m_werrs = 0;
          end
        end
      endcase
    end
    if (c) m_err = 0;
  endtask

  // ---------------- stimulus generator (reference LFSR stream) ----------------
  logic [7:0] gen_a, gen_b;

  task automatic gen_next(inout logic [7:0] g, output logic b);
    b = g[0] ^ g[2] ^ g[3] ^ g[4];
    g = {b, g[7:1]};
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic v, input logic b, input logic c, input logic r);
    rst = r; bit_valid = v; bit_in = b; clr_err = c;
    model_step(v, b, c, r);
    @(posedge clk);
    #1;
    check("state",     32'(state),     32'(m_mode));
    check("locked",    32'(locked),    32'(m_mode == 2));
    check("err_cnt",   32'(err_cnt),   32'(m_err));
    check("err_pulse", 32'(err_pulse), 32'(m_pulse));
    if (locked) ever_locked = 1'b1;
  endtask

  task automatic clean(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      gen_next(gen_a, b);
      step(1'b1, b, 1'b0, 1'b0);
    end
  endtask

  task automatic flip(input logic c);
    logic b;
    gen_next(gen_a, b);
    step(1'b1, ~b, c, 1'b0);
  endtask

  task automatic sat_step(input logic v, input logic b);
    s_valid = v; s_bit = b;
    @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int   acc;
    int   cyc;
    logic b;
    int   exp_sat;

    rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; clr_err = 1'b0;
    s_rst = 1'b1; s_valid = 1'b0; s_bit = 1'b0; s_clr = 1'b0;
    gen_a = 8'h01;
    gen_b = 8'h01;
    ever_locked = 1'b0;

    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b1);
    s_rst = 1'b0;
    check("rst_state",  32'(state),     32'd0);
    check("rst_locked", 32'(locked),    32'd0);
    check("rst_err",    32'(err_cnt),   32'd0);
    check("rst_pulse",  32'(err_pulse), 32'd0);

    // Clean lock after exactly 8+LOCK_CNT accepted bits
    for (int i = 1; i <= 8 + LOCK_CNT; i++) begin
      clean(1);
      if (i == 8 + LOCK_CNT - 1) check("prelock", 32'(locked), 32'd0);
    end
    check("lock_at_24", 32'(locked), 32'd1);
    clean(1000);
    check("clean_err", 32'(err_cnt), 32'd0);
    check("clean_locked", 32'(locked), 32'd1);

    // Single flipped bit
    flip(1'b0);
    check("single_err",   32'(err_cnt),   32'd1);
    check("single_pulse", 32'(err_pulse), 32'd1);
    clean(1);
    check("pulse_width",  32'(err_pulse), 32'd0);
    check("single_lock",  32'(locked),    32'd1);

    // Loss of lock: clear errors, align to a window start, then 4 errors
    gen_next(gen_a, b);
    step(1'b1, b, 1'b1, 1'b0);
    check("clr_err", 32'(err_cnt), 32'd0);
    cyc = 0;
    while (m_wbits != 0 && cyc < 2 * WINDOW) begin
      clean(1);
      cyc++;
    end
    check("window_align", 32'(m_wbits), 32'd0);
    for (int k = 0; k < ERR_LIMIT; k++) begin
      check("lol_still_locked", 32'(locked), 32'd1);
      flip(1'b0);
      if (k < ERR_LIMIT - 1) clean(1);
    end
    check("lol_state", 32'(state),   32'd0);
    check("lol_err",   32'(err_cnt), 32'd4);
    clean(8 + LOCK_CNT - 1);
    check("relock_pre", 32'(locked), 32'd0);
    clean(1);
    check("relock", 32'(locked), 32'd1);

    // Lockup guard and VERIFY failure
    step(1'b0, 1'b0, 1'b0, 1'b1);
    ever_locked = 1'b0;
    repeat (8) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("lockup_hunt", 32'(state), 32'd0);
    clean(8);
    check("verify_entry", 32'(state), 32'd1);
    clean(9);
    check("verify_9", 32'(state), 32'd1);
    flip(1'b0);
    check("verify_fail", 32'(state),   32'd0);
    check("verify_err",  32'(err_cnt), 32'd0);
    check("never_locked", 32'(ever_locked), 32'd0);
    clean(8 + LOCK_CNT);
    check("verify_relock", 32'(locked), 32'd1);

    // Gapped input at ~30% duty
    step(1'b0, 1'b0, 1'b0, 1'b1);
    acc = 0;
    cyc = 0;
    while (acc < 8 + LOCK_CNT && cyc < 2000) begin
      if ($urandom_range(0, 99) < 30) begin
        clean(1);
        acc++;
        if (acc == 8 + LOCK_CNT - 1) check("gap_prelock", 32'(locked), 32'd0);
      end else begin
        step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      cyc++;
    end
    check("gap_accepted", 32'(acc), 32'd24);
    check("gap_lock", 32'(locked), 32'd1);

    // Mismatch with and without clr_err, plus clr_err on an idle cycle
    clean(5);
    flip(1'b0);
    check("gap_err1", 32'(err_cnt), 32'd1);
    repeat (3) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    flip(1'b1);
    check("clr_mis_err",   32'(err_cnt),   32'd0);
    check("clr_mis_pulse", 32'(err_pulse), 32'd1);
    flip(1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("clr_idle", 32'(err_cnt), 32'd0);
    clean(2 * WINDOW);

    // Reset while locked, then reset mid-VERIFY
    flip(1'b0);
    clean(2);
    check("pre_rst_err",  32'(err_cnt), 32'd1);
    check("pre_rst_lock", 32'(locked),  32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("rst_lock_locked", 32'(locked),  32'd0);
    check("rst_lock_err",    32'(err_cnt), 32'd0);
    clean(12);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    clean(8 + LOCK_CNT - 1);
    check("rst_verify_pre", 32'(locked), 32'd0);
    clean(1);
    check("rst_verify_lock", 32'(locked), 32'd1);

    // Saturation on u_sat: lock cleanly, then every bit mismatches
    for (int i = 0; i < 8 + LOCK_CNT; i++) begin
      gen_next(gen_b, b);
      sat_step(1'b1, b);
    end
    check("sat_lock", 32'(s_locked), 32'd1);
    for (int i = 1; i <= 65540; i++) begin
      gen_next(gen_b, b);
      sat_step(1'b1, ~b);
      if ((i % 8192) == 0 || i >= 65533) begin
        exp_sat = (i > 65535) ? 65535 : i;
        check("sat_err", 32'(s_err), 32'(exp_sat));
      end
    end
    check("sat_pulse",  32'(s_pulse),  32'd1);
    check("sat_locked", 32'(s_locked), 32'd1);
    check("sat_hold",   32'(s_err),    32'h0000FFFF);
    s_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
